// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin owner of the single RAM port with a per-tenure access cap.
// Translates ramstate into per-requester wait/ack for NREQ cache-side requesters.
module ram_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NREQ-1:0]            req_ren,
    input  logic [NREQ-1:0]            req_wen,
    input  logic [NREQ-1:0][31:0]      req_addr,
    input  logic [NREQ-1:0][31:0]      req_store,
    output logic [NREQ-1:0]            req_wait,
    output logic [31:0]                req_load,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [31:0]                ramaddr,
    output logic [31:0]                ramstore,
    input  logic [31:0]                ramload,
    input  logic [1:0]                 ramstate,
    output logic                       grant_vld,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       ram_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int HCW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Returns {found, index} of the first active requester after 'last', wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] act,
                                             input logic [IDW-1:0]  last);
        logic [IDW:0] res;
        int           idx;
        res = {(IDW+1){1'b0}};
        // Walk from farthest to nearest so the nearest active index is written last.
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (act[idx]) begin
                res = {1'b1, idx[IDW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [0:0]       state_r;
    logic [0:0]       state_n_s;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   ptr_n_s;
    logic [HCW-1:0]   hold_cnt_r;
    logic [HCW-1:0]   hold_cnt_n_s;
    logic [IDW-1:0]   grant_id_r;
    logic [IDW-1:0]   grant_id_n_s;

    logic [NREQ-1:0]  active_s;
    logic             owned_s;
    logic             own_active_s;
    logic             ack_s;
    logic [IDW:0]     pick_s;

    assign active_s     = req_ren | req_wen;
    assign owned_s      = (state_r == ST_OWN);
    assign own_active_s = owned_s & active_s[grant_id_r];
    assign ack_s        = own_active_s & (ramstate == RS_ACCESS);
    assign pick_s       = rr_pick(active_s, ptr_r);

    assign req_load  = ramload;
    assign grant_vld = owned_s;
    assign grant_id  = grant_id_r;

    // RAM port mux and per-requester wait generation from the current owner.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0000_0000;
        ramstore = 32'h0000_0000;
        req_wait = {NREQ{1'b1}};
        ram_err  = 1'b0;
        if (owned_s) begin
            // Write wins when an owner raises both enables.
            ramWEN               = req_wen[grant_id_r];
            ramREN               = req_ren[grant_id_r] & ~req_wen[grant_id_r];
            ramaddr              = req_addr[grant_id_r];
            ramstore             = req_store[grant_id_r];
            req_wait[grant_id_r] = ~ack_s;
            ram_err              = (ramstate == RS_ERROR);
        end else begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = 32'h0000_0000;
            ramstore = 32'h0000_0000;
            req_wait = {NREQ{1'b1}};
            ram_err  = 1'b0;
        end
    end

    // Next-state logic: arbitration in IDLE, tenure accounting and release in OWN.
    always_comb begin
        state_n_s    = state_r;
        ptr_n_s      = ptr_r;
        hold_cnt_n_s = hold_cnt_r;
        grant_id_n_s = grant_id_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[IDW]) begin
                    state_n_s    = ST_OWN;
                    grant_id_n_s = pick_s[IDW-1:0];
                    hold_cnt_n_s = {HCW{1'b0}};
                end else begin
                    state_n_s    = ST_IDLE;
                    grant_id_n_s = {IDW{1'b0}};
                end
            end
            ST_OWN: begin
                if (!own_active_s || (ramstate == RS_ERROR)) begin
                    state_n_s    = ST_IDLE;
                    ptr_n_s      = grant_id_r;
                    hold_cnt_n_s = {HCW{1'b0}};
                    grant_id_n_s = {IDW{1'b0}};
                end else if (ramstate == RS_ACCESS) begin
                    if (hold_cnt_r == HCW'(MAX_HOLD - 1)) begin
                        state_n_s    = ST_IDLE;
                        ptr_n_s      = grant_id_r;
                        hold_cnt_n_s = {HCW{1'b0}};
                        grant_id_n_s = {IDW{1'b0}};
                    end else begin
                        hold_cnt_n_s = hold_cnt_r + HCW'(1'b1);
                    end
                end else begin
                    // FREE/BUSY: keep the port and wait for the RAM.
                    state_n_s = ST_OWN;
                end
            end
            default: begin
                state_n_s    = ST_IDLE;
                hold_cnt_n_s = {HCW{1'b0}};
                grant_id_n_s = {IDW{1'b0}};
            end
        endcase
    end

    // State, round-robin pointer, tenure counter and grant registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= ST_IDLE;
            ptr_r      <= IDW'(NREQ - 1);
            hold_cnt_r <= {HCW{1'b0}};
            grant_id_r <= {IDW{1'b0}};
        end else begin
            state_r    <= state_n_s;
            ptr_r      <= ptr_n_s;
            hold_cnt_r <= hold_cnt_n_s;
            grant_id_r <= grant_id_n_s;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic
// compared every cycle against a tenure-level reference model.
module tb_ram_port_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 8;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [NREQ-1:0]       req_ren;
    logic [NREQ-1:0]       req_wen;
    logic [NREQ-1:0][31:0] req_addr;
    logic [NREQ-1:0][31:0] req_store;
    logic [NREQ-1:0]       req_wait;
    logic [31:0]           req_load;
    logic                  ramREN;
    logic                  ramWEN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramstore;
    logic [31:0]           ramload;
    logic [1:0]            ramstate;
    logic                  grant_vld;
    logic [1:0]            grant_id;
    logic                  ram_err;

    ram_port_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .grant_vld(grant_vld), .grant_id(grant_id), .ram_err(ram_err)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the port, who released last, accesses done this tenure.
    bit m_own;
    int m_owner;
    int m_last;
    int m_taken;

    // Observations of the most recent cycle, for directed checks.
    logic [NREQ-1:0] obs_wait;
    logic            obs_vld;
    logic [1:0]      obs_gid;
    logic            obs_ren;
    logic            obs_wen;
    logic [31:0]     obs_addr;
    logic            obs_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own   = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_taken = 0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i]  = $urandom;
            req_store[i] = $urandom;
        end
    endtask

    // One clock cycle: drive at negedge, compare model vs DUT, then advance both.
    task automatic run_cycle(input logic [NREQ-1:0] ren, input logic [NREQ-1:0] wen,
                             input logic [1:0] st);
        logic [NREQ-1:0] act;
        logic [NREQ-1:0] e_wait;
        logic            e_ren, e_wen, e_err;
        logic [31:0]     e_addr, e_store;
        int              e_gid;
        req_ren  = ren;
        req_wen  = wen;
        ramstate = st;
        ramload  = $urandom;
        #1;
        act     = ren | wen;
        e_wait  = {NREQ{1'b1}};
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_err   = 1'b0;
        e_addr  = 32'h0;
        e_store = 32'h0;
        e_gid   = 0;
        if (m_own) begin
            e_gid   = m_owner;
            e_wen   = wen[m_owner];
            e_ren   = ren[m_owner] & ~wen[m_owner];
            e_addr  = req_addr[m_owner];
            e_store = req_store[m_owner];
            e_err   = (st == RS_ERROR);
            if (act[m_owner] && st == RS_ACCESS) e_wait[m_owner] = 1'b0;
        end
        check_val("grant_vld", 64'(grant_vld), 64'(m_own));
        check_val("grant_id",  64'(grant_id),  64'(e_gid));
        check_val("req_wait",  64'(req_wait),  64'(e_wait));
        check_val("ramREN",    64'(ramREN),    64'(e_ren));
        check_val("ramWEN",    64'(ramWEN),    64'(e_wen));
        check_val("ramaddr",   64'(ramaddr),   64'(e_addr));
        check_val("ramstore",  64'(ramstore),  64'(e_store));
        check_val("ram_err",   64'(ram_err),   64'(e_err));
        check_val("req_load",  64'(req_load),  64'(ramload));
        obs_wait = req_wait;
        obs_vld  = grant_vld;
        obs_gid  = grant_id;
        obs_ren  = ramREN;
        obs_wen  = ramWEN;
        obs_addr = ramaddr;
        obs_err  = ram_err;
        @(posedge CLK);
        if (m_own) begin
            if (!act[m_owner] || st == RS_ERROR) begin
                m_own = 1'b0; m_last = m_owner; m_taken = 0;
            end else if (st == RS_ACCESS) begin
                m_taken++;
                if (m_taken == MAX_HOLD) begin
                    m_own = 1'b0; m_last = m_owner; m_taken = 0;
                end
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!m_own && act[(m_last + k) % NREQ]) begin
                    m_own = 1'b1; m_owner = (m_last + k) % NREQ; m_taken = 0;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST     = 1'b0;
        req_ren  = '0;
        req_wen  = '0;
        ramstate = RS_FREE;
        ramload  = 32'h0;
        rand_data();
        @(negedge CLK);
        #1;
        check_val("rst_vld",  64'(grant_vld), 64'd0);
        check_val("rst_gid",  64'(grant_id),  64'd0);
        check_val("rst_wait", 64'(req_wait),  64'hF);
        check_val("rst_en",   64'({ramREN, ramWEN}), 64'd0);
        check_val("rst_addr", 64'(ramaddr),   64'd0);
        check_val("rst_stor", 64'(ramstore),  64'd0);
        check_val("rst_err",  64'(ram_err),   64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
    endtask

    initial begin
        int gq[$];
        int aq[$];
        int exp_acks[$];
        logic prev_vld;
        int cnt0, cnt2;
        logic [NREQ-1:0] rr, ww;

        // 1: single reader, ack on the second owned cycle
        do_reset();
        run_cycle(4'b0001, 4'b0000, RS_FREE);
        run_cycle(4'b0001, 4'b0000, RS_BUSY);
        check_val("t1_grant", 64'({obs_vld, obs_gid}), 64'({1'b1, 2'd0}));
        check_val("t1_wait_busy", 64'(obs_wait), 64'hF);
        run_cycle(4'b0001, 4'b0000, RS_ACCESS);
        check_val("t1_ack", 64'(obs_wait), 64'hE);
        run_cycle(4'b0000, 4'b0000, RS_ACCESS);
        check_val("t1_one_ack", 64'(obs_wait), 64'hF);

        // 2: all reading, RAM always ready -> grants rotate 0,1,2,3,0
        do_reset();
        prev_vld = 1'b0;
        for (int c = 0; c < 100 && gq.size() < 5; c++) begin
            rand_data();
            run_cycle(4'b1111, 4'b0000, RS_ACCESS);
            if (obs_vld && !prev_vld) gq.push_back(int'(obs_gid));
            prev_vld = obs_vld;
        end
        check_val("t2_count", 64'(gq.size()), 64'd5);
        for (int i = 0; i < gq.size() && i < 5; i++)
            check_val("t2_order", 64'(gq[i]), 64'(i % NREQ));

        // 3: tenure cap hands the port to requester 0 after 8 writes by requester 2
        do_reset();
        cnt0 = 0; cnt2 = 0;
        for (int c = 0; c < 200 && !(cnt2 == 10 && cnt0 == 1); c++) begin
            rand_data();
            rr = '0; ww = '0;
            if (c >= 1 && cnt0 < 1) rr[0] = 1'b1;
            if (cnt2 < 10) ww[2] = 1'b1;
            run_cycle(rr, ww, RS_ACCESS);
            for (int i = 0; i < NREQ; i++) begin
                if (!obs_wait[i]) begin
                    aq.push_back(i);
                    if (i == 0) cnt0++;
                    if (i == 2) cnt2++;
                end
            end
        end
        for (int i = 0; i < 8; i++) exp_acks.push_back(2);
        exp_acks.push_back(0); exp_acks.push_back(2); exp_acks.push_back(2);
        check_val("t3_count", 64'(aq.size()), 64'(exp_acks.size()));
        for (int i = 0; i < aq.size() && i < exp_acks.size(); i++)
            check_val("t3_seq", 64'(aq[i]), 64'(exp_acks[i]));

        // 4: ren+wen from owner 1 -> write wins
        do_reset();
        req_addr[1]  = 32'h0000_0040;
        req_store[1] = 32'hA5C3_0F1E;
        run_cycle(4'b0010, 4'b0010, RS_FREE);
        run_cycle(4'b0010, 4'b0010, RS_BUSY);
        check_val("t4_wen",  64'(obs_wen),  64'd1);
        check_val("t4_ren",  64'(obs_ren),  64'd0);
        check_val("t4_addr", 64'(obs_addr), 64'h40);
        run_cycle(4'b0010, 4'b0010, RS_ACCESS);
        run_cycle(4'b0000, 4'b0000, RS_FREE);

        // 5: ERROR while owner 3 reads; pointer must end at 3 (prior owner was 1)
        run_cycle(4'b1000, 4'b0000, RS_FREE);
        run_cycle(4'b1000, 4'b0000, RS_ERROR);
        check_val("t5_err",  64'(obs_err), 64'd1);
        check_val("t5_wait", 64'(obs_wait), 64'hF);
        run_cycle(4'b0000, 4'b0000, RS_ERROR);
        check_val("t5_idle", 64'({obs_vld, obs_err}), 64'd0);
        run_cycle(4'b0101, 4'b0000, RS_FREE);
        run_cycle(4'b0101, 4'b0000, RS_FREE);
        check_val("t5_ptr", 64'({obs_vld, obs_gid}), 64'({1'b1, 2'd0}));
        run_cycle(4'b0000, 4'b0000, RS_FREE);

        // 6: reset during BUSY of owner 0
        do_reset();
        run_cycle(4'b0001, 4'b0000, RS_FREE);
        req_ren = 4'b0001; ramstate = RS_BUSY; #1;
        check_val("t6_pre_ren", 64'(ramREN), 64'd1);
        nRST = 1'b0; #1;
        check_val("t6_ren",  64'(ramREN),    64'd0);
        check_val("t6_vld",  64'(grant_vld), 64'd0);
        check_val("t6_wait", 64'(req_wait),  64'hF);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        run_cycle(4'b1111, 4'b0000, RS_ACCESS);
        run_cycle(4'b1111, 4'b0000, RS_ACCESS);
        check_val("t6_regrant", 64'({obs_vld, obs_gid}), 64'({1'b1, 2'd0}));

        // Random traffic against the model
        do_reset();
        rr = '0; ww = '0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [1:0] st;
            rand_data();
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 4) == 0) rr[i] = ~rr[i];
                if ($urandom_range(0, 5) == 0) ww[i] = ~ww[i];
            end
            r = $urandom_range(0, 9);
            if (r == 0)      st = RS_ERROR;
            else if (r <= 2) st = RS_FREE;
            else if (r <= 4) st = RS_BUSY;
            else             st = RS_ACCESS;
            run_cycle(rr, ww, st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
